// File: rtl/oflow_pkg.sv
// oflow feature-extraction scheduler shared types and sizes.
// Bank geometry and FSM encoding used by the scheduler and its bench.
package oflow_pkg;

  localparam int BBOX_VECTOR_SIZE = 89;
  localparam int NUM_FE           = 4;
  localparam int MAX_OBJ          = 32;
  localparam int CNT_W            = $clog2(MAX_OBJ + 1);
  localparam int SLOT_W           = $clog2(NUM_FE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_WAIT_ACK,
    S_DONE
  } fe_sched_state_t;

endpackage

// File: rtl/oflow_fe_scheduler.sv
// Per-frame round-robin bbox dispatcher for the oflow FE bank.
// Loads up to NUM_FE bboxes per group, then holds until the scorer acks.
module oflow_fe_scheduler
  import oflow_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_N,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_of_bbox,
  input  logic [BBOX_VECTOR_SIZE-1:0] bbox_in,
  input  logic                        bbox_valid,
  output logic                        bbox_ready,
  output logic [BBOX_VECTOR_SIZE-1:0] fe_bbox,
  output logic [NUM_FE-1:0]           fe_enable,
  output logic [CNT_W-1:0]            fe_obj_id,
  output logic                        group_valid,
  output logic [NUM_FE-1:0]           group_mask,
  input  logic                        group_ack,
  output logic                        busy,
  output logic                        frame_done
);

  fe_sched_state_t r_state;
  fe_sched_state_t w_state_nxt;

  logic [CNT_W-1:0]            r_remaining;
  logic [CNT_W-1:0]            r_obj_id;
  logic [SLOT_W-1:0]           r_slot;
  logic [NUM_FE-1:0]           r_mask;
  logic [BBOX_VECTOR_SIZE-1:0] r_fe_bbox;
  logic [NUM_FE-1:0]           r_fe_enable;
  logic [CNT_W-1:0]            r_fe_obj_id;

  logic             w_hs;
  logic             w_last;
  logic             w_ack;
  logic             w_go;
  logic [CNT_W-1:0] w_num_sat;

  assign w_num_sat = (num_of_bbox > CNT_W'(MAX_OBJ))
                   ? CNT_W'(MAX_OBJ) : num_of_bbox;

  assign w_go   = start && (r_state == S_IDLE);
  assign w_hs   = bbox_valid && (r_state == S_LOAD);
  assign w_ack  = group_ack && (r_state == S_WAIT_ACK);
  assign w_last = (r_slot == SLOT_W'(NUM_FE - 1))
               || (r_remaining == CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_num_sat != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (w_hs && w_last) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (group_ack) begin
          w_state_nxt = (r_remaining == '0) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FE strobe is a single-cycle pulse; data/id hold between handshakes.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_remaining <= '0;
      r_obj_id    <= '0;
      r_slot      <= '0;
      r_mask      <= '0;
      r_fe_bbox   <= '0;
      r_fe_enable <= '0;
      r_fe_obj_id <= '0;
    end else begin
      r_fe_enable <= '0;
      if (w_go) begin
        r_remaining <= w_num_sat;
        r_obj_id    <= '0;
        r_slot      <= '0;
        r_mask      <= '0;
      end
      if (w_hs) begin
        r_fe_bbox      <= bbox_in;
        r_fe_enable    <= NUM_FE'(1) << r_slot;
        r_fe_obj_id    <= r_obj_id;
        r_mask[r_slot] <= 1'b1;
        r_slot         <= r_slot + 1'b1;
        r_obj_id       <= r_obj_id + 1'b1;
        r_remaining    <= r_remaining - 1'b1;
      end
      if (w_ack) begin
        r_slot <= '0;
        r_mask <= '0;
      end
    end
  end

  assign bbox_ready  = (r_state == S_LOAD);
  assign group_valid = (r_state == S_WAIT_ACK);
  assign group_mask  = group_valid ? r_mask : '0;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = (r_state == S_DONE);
  assign fe_bbox     = r_fe_bbox;
  assign fe_enable   = r_fe_enable;
  assign fe_obj_id   = r_fe_obj_id;

endmodule

// File: tb/tb_oflow_fe_scheduler.sv
// Directed scenario bench for oflow_fe_scheduler (NUM_FE=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_oflow_fe_scheduler;
  import oflow_pkg::*;

  logic                        clk;
  logic                        reset_N;
  logic                        start;
  logic [CNT_W-1:0]            num_of_bbox;
  logic [BBOX_VECTOR_SIZE-1:0] bbox_in;
  logic                        bbox_valid;
  logic                        bbox_ready;
  logic [BBOX_VECTOR_SIZE-1:0] fe_bbox;
  logic [NUM_FE-1:0]           fe_enable;
  logic [CNT_W-1:0]            fe_obj_id;
  logic                        group_valid;
  logic [NUM_FE-1:0]           group_mask;
  logic                        group_ack;
  logic                        busy;
  logic                        frame_done;

  int checks = 0;
  int errors = 0;

  oflow_fe_scheduler dut (
    .clk         (clk),
    .reset_N     (reset_N),
    .start       (start),
    .num_of_bbox (num_of_bbox),
    .bbox_in     (bbox_in),
    .bbox_valid  (bbox_valid),
    .bbox_ready  (bbox_ready),
    .fe_bbox     (fe_bbox),
    .fe_enable   (fe_enable),
    .fe_obj_id   (fe_obj_id),
    .group_valid (group_valid),
    .group_mask  (group_mask),
    .group_ack   (group_ack),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BBOX_VECTOR_SIZE-1:0] pat(input int i);
    logic [BBOX_VECTOR_SIZE-1:0] v;
    v = '0;
    v[15:0]  = 16'(i);
    v[47:40] = 8'(i * 7 + 3);
    v[BBOX_VECTOR_SIZE-1 -: 8] = 8'hA5 ^ 8'(i);
    return v;
  endfunction

  task automatic do_start(input int num);
    start       = 1'b1;
    num_of_bbox = CNT_W'(num);
    @(negedge clk);
    start       = 1'b0;
    num_of_bbox = '0;
  endtask

  // Valid held high: expect one-hot strobes from slot 0 upward.
  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bbox_ready !== 1'b1) begin
        errors++;
        $display("FAIL feed_ready id%0d: got %b exp 1",
                 base + i, bbox_ready);
      end
      bbox_in    = pat(base + i);
      bbox_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (fe_enable !== NUM_FE'(1 << i)) begin
        errors++;
        $display("FAIL feed_en id%0d: got %b exp %b",
                 base + i, fe_enable, NUM_FE'(1 << i));
      end
      checks++;
      if (fe_obj_id !== CNT_W'(base + i)) begin
        errors++;
        $display("FAIL feed_objid: got %0d exp %0d",
                 fe_obj_id, base + i);
      end
      checks++;
      if (fe_bbox !== pat(base + i)) begin
        errors++;
        $display("FAIL feed_bbox id%0d: got %h exp %h",
                 base + i, fe_bbox, pat(base + i));
      end
    end
    bbox_valid = 1'b0;
    checks++;
    if (bbox_ready !== 1'b0) begin
      errors++;
      $display("FAIL settle_ready: got %b exp 0", bbox_ready);
    end
  endtask

  // Called one cycle after the last strobe (SETTLE).
  task automatic ack_group(input logic [NUM_FE-1:0] m,
                           input bit last);
    @(negedge clk);
    checks++;
    if (group_valid !== 1'b1 || group_mask !== m) begin
      errors++;
      $display("FAIL group: got v=%b m=%b exp v=1 m=%b",
               group_valid, group_mask, m);
    end
    checks++;
    if (fe_enable !== '0 || bbox_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold: got en=%b rdy=%b exp 0 0",
               fe_enable, bbox_ready);
    end
    @(negedge clk);
    checks++;
    if (group_valid !== 1'b1) begin
      errors++;
      $display("FAIL group_hold: got %b exp 1", group_valid);
    end
    group_ack = 1'b1;
    @(negedge clk);
    group_ack = 1'b0;
    checks++;
    if (group_valid !== 1'b0 || frame_done !== last) begin
      errors++;
      $display("FAIL post_ack: got v=%b fd=%b exp v=0 fd=%b",
               group_valid, frame_done, last);
    end
    if (last) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle: got fd=%b busy=%b exp 0 0",
                 frame_done, busy);
      end
    end else begin
      checks++;
      if (bbox_ready !== 1'b1) begin
        errors++;
        $display("FAIL reload: got rdy=%b exp 1", bbox_ready);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bbox_ready, group_valid, busy, frame_done} !== 4'b0 ||
        fe_enable !== '0 || group_mask !== '0 ||
        fe_obj_id !== '0 || fe_bbox !== '0) begin
      errors++;
      $display("FAIL reset: got rdy%b gv%b b%b fd%b en%b",
               bbox_ready, group_valid, busy, frame_done, fe_enable);
    end
    @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bbox_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b exp 0 0",
               busy, bbox_ready);
    end
  endtask

  task automatic test_single_group();
    do_start(4);
    checks++;
    if (busy !== 1'b1 || fe_enable !== '0) begin
      errors++;
      $display("FAIL load_entry: got busy=%b en=%b exp 1 0000",
               busy, fe_enable);
    end
    feed(4, 0);
    ack_group(4'b1111, 1'b1);
  endtask

  task automatic test_two_groups();
    do_start(6);
    feed(4, 0);
    ack_group(4'b1111, 1'b0);
    feed(2, 4);
    ack_group(4'b0011, 1'b1);
  endtask

  task automatic test_zero();
    bbox_valid = 1'b1;
    bbox_in    = pat(99);
    @(negedge clk);
    checks++;
    if (fe_enable !== '0 || bbox_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got en=%b rdy=%b exp 0 0",
               fe_enable, bbox_ready);
    end
    do_start(0);
    checks++;
    if (frame_done !== 1'b1 || bbox_ready !== 1'b0 ||
        fe_enable !== '0) begin
      errors++;
      $display("FAIL zero_done: got fd=%b rdy=%b en=%b exp 1 0 0",
               frame_done, bbox_ready, fe_enable);
    end
    @(negedge clk);
    bbox_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got fd=%b busy=%b exp 0 0",
               frame_done, busy);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] vpat;
    logic [3:0] en_exp [4];
    int         id_exp [4];
    vpat   = 4'b1001;
    en_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
    id_exp = '{0, 0, 0, 1};
    do_start(2);
    for (int c = 0; c < 4; c++) begin
      bbox_valid = vpat[3 - c];
      bbox_in    = pat(20 + c);
      @(negedge clk);
      checks++;
      if (fe_enable !== en_exp[c] ||
          fe_obj_id !== CNT_W'(id_exp[c])) begin
        errors++;
        $display("FAIL gap c%0d: got en=%b id=%0d exp %b %0d",
                 c, fe_enable, fe_obj_id, en_exp[c], id_exp[c]);
      end
    end
    bbox_valid = 1'b0;
    checks++;
    if (bbox_ready !== 1'b0 || fe_bbox !== pat(23)) begin
      errors++;
      $display("FAIL gap_end: got rdy=%b bbox=%h", bbox_ready, fe_bbox);
    end
    ack_group(4'b0011, 1'b1);
  endtask

  task automatic test_stray_inputs();
    do_start(3);
    bbox_valid  = 1'b1;
    bbox_in     = pat(0);
    start       = 1'b1;
    num_of_bbox = CNT_W'(0);
    group_ack   = 1'b1;
    @(negedge clk);
    checks++;
    if (fe_enable !== 4'b0001 || bbox_ready !== 1'b1 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL stray1: got en=%b rdy=%b fd=%b exp 0001 1 0",
               fe_enable, bbox_ready, frame_done);
    end
    bbox_valid = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    group_ack = 1'b0;
    checks++;
    if (fe_enable !== '0 || bbox_ready !== 1'b1 ||
        group_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray2: got en=%b rdy=%b gv=%b exp 0000 1 0",
               fe_enable, bbox_ready, group_valid);
    end
    bbox_valid = 1'b1;
    bbox_in    = pat(1);
    @(negedge clk);
    checks++;
    if (fe_enable !== 4'b0010 || fe_obj_id !== CNT_W'(1)) begin
      errors++;
      $display("FAIL stray3: got en=%b id=%0d exp 0010 1",
               fe_enable, fe_obj_id);
    end
    bbox_in = pat(2);
    @(negedge clk);
    bbox_valid = 1'b0;
    checks++;
    if (fe_enable !== 4'b0100 || fe_obj_id !== CNT_W'(2) ||
        bbox_ready !== 1'b0) begin
      errors++;
      $display("FAIL stray4: got en=%b id=%0d rdy=%b exp 0100 2 0",
               fe_enable, fe_obj_id, bbox_ready);
    end
    ack_group(4'b0111, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    do_start(6);
    feed(4, 0);
    @(negedge clk);
    checks++;
    if (group_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_gv: got %b exp 1", group_valid);
    end
    reset_N = 1'b0;
    #1;
    checks++;
    if ({bbox_ready, group_valid, busy, frame_done} !== 4'b0 ||
        fe_enable !== '0 || group_mask !== '0 ||
        fe_obj_id !== '0 || fe_bbox !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy%b gv%b b%b fd%b m%b id%0d",
               bbox_ready, group_valid, busy, frame_done,
               group_mask, fe_obj_id);
    end
    @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got fd=%b busy=%b exp 0 0",
               frame_done, busy);
    end
    do_start(1);
    feed(1, 0);
    ack_group(4'b0001, 1'b1);
  endtask

  task automatic test_saturate();
    do_start(40);
    for (int g = 0; g < MAX_OBJ / NUM_FE; g++) begin
      feed(NUM_FE, g * NUM_FE);
      ack_group(4'b1111, g == MAX_OBJ / NUM_FE - 1);
    end
  endtask

  initial begin
    reset_N     = 1'b0;
    start       = 1'b0;
    num_of_bbox = '0;
    bbox_in     = '0;
    bbox_valid  = 1'b0;
    group_ack   = 1'b0;
    test_reset();
    test_single_group();
    test_two_groups();
    test_zero();
    test_gaps();
    test_stray_inputs();
    test_reset_mid_frame();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
